lfsr_multi: RTL and testbench
=============================

Name: lfsr_multi

Overview:
- Parametrised successor to the team's fixed 7-bit LFSR.
- Generates a maximal-length pseudo-random sequence from a polynomial set at elaboration time.
- Supports run-time selection of Fibonacci or Galois form, seed loading, and advancing several bits per clock.
- Includes all-zero lock-up protection and a period monitor. Used as the stimulus/random source for the reaction-timer and FSM labs.

Parameters:
- WIDTH, 7: state width in bits, 3..32.
- POLY, 7'h09: low-order polynomial coefficients; bit k = coefficient of x^k, k=0..WIDTH-1; x^WIDTH implied; POLY[0] must be 1. Default is x^7+x^3+1.
- STEPS, 1: LFSR shifts per enabled cycle, 1..WIDTH.
- SEED, 1: reset/default seed, WIDTH bits, must be non-zero.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  advance STEPS shifts this cycle
- load  in  1  load seed_in and latch mode this cycle
- seed_in  in  WIDTH  seed value for load
- mode  in  1  0 = Fibonacci, 1 = Galois; sampled only on load
- data_out  out  WIDTH  current state register
- bit_out  out  STEPS  bits shifted out during the last enabled cycle
- zero_seed_err  out  1  one-cycle pulse: all-zero seed rejected
- period_pulse  out  1  one-cycle pulse: state returned to the loaded seed
- period_len  out  32  enabled-cycle count of the last completed period

Behaviour:
- All outputs are registered. data_out is the state register itself, with no extra pipeline stage.
- Priority is rst > load > en; with none asserted, all registers hold (pulses drop to 0).
- Reset values:
  - state = SEED; active seed register = SEED; mode_r = 0.
  - bit_out = 0; zero_seed_err = 0; period_pulse = 0.
  - period_len = 0; internal cycle counter = 0.
- Single shift, state s, bit positions 0-indexed. Shifted-out bit is s[WIDTH-1] in both forms.
  - Fibonacci: fb = s[WIDTH-1] XOR s[k-1] for every k in 1..WIDTH-1 with POLY[k]=1; next = {s[WIDTH-2:0], fb}.
  - Galois: next = {s[WIDTH-2:0], 0} XOR (POLY if s[WIDTH-1] else 0).
- en cycle:
  - Applies the shift STEPS times combinationally (unrolled chain) and registers the result.
  - bit_out[i] = bit shifted out at shift i; bit_out[0] is the first.
  - bit_out holds its value on non-enabled cycles.
- load cycle:
  - seed_in != 0: state = seed_in, active seed = seed_in.
  - seed_in == 0: state = SEED, active seed = SEED, zero_seed_err = 1 for that cycle.
  - mode_r = mode. Cycle counter cleared. period_len unchanged. en is ignored that cycle.
- Lock-up guard: if state is ever 0 at an enabled cycle (SEU/X recovery), state reloads the active seed instead of shifting and zero_seed_err pulses.
- Period monitor:
  - Counter increments on each enabled cycle; it is a 32-bit counter that saturates at 2^32-1.
  - When the next state equals the active seed: period_pulse = 1 in the cycle data_out shows the seed, period_len = counter+1, counter = 0.
  - Exact for STEPS=1. For STEPS>1 it detects only cycle-aligned returns; no pulse otherwise.
- mode changes without load have no effect.
- Reset mid-sequence returns to SEED and Fibonacci form on the next edge, regardless of en/load.

Test Plan:
- Fibonacci sequence: rst, then en held, STEPS=1, defaults -> data_out 0x01, 0x02, 0x04, 0x09, 0x12, 0x24, 0x49; period_pulse after 127 enabled cycles; period_len = 127.
- Galois sequence: load with seed_in=0x01, mode=1, then en held -> data_out 0x01, 0x02, 0x04, 0x08, 0x10, 0x20, 0x40, 0x09, 0x12; period_len = 127; all 127 non-zero states visited exactly once.
- Zero seed: load with seed_in=0 -> zero_seed_err pulses 1 cycle; data_out = 0x01; sequence continues normally.
- Multi-step: STEPS=2 build, reset, en for 2 cycles -> data_out 0x04 then 0x12; bit_out = 2'b00 each cycle. Compare against the STEPS=1 model every 2 shifts for 1000 cycles.
- Priority/hold:
  - en=0 -> data_out and bit_out hold.
  - load and en in the same cycle -> load wins; data_out = seed_in.
  - rst asserted mid-run together with load -> data_out = 0x01, mode Fibonacci, period counter cleared.
- Lock-up guard: force state to 0 via hierarchical deposit, en=1 -> next data_out = active seed; zero_seed_err pulses.

Source files
------------

// File: rtl/lfsr_multi.sv
// Parametrised LFSR with run-time Fibonacci/Galois selection, multi-step advance,
// all-zero lock-up recovery and a period monitor.
module lfsr_multi #(
  parameter int unsigned      WIDTH = 7,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(7'h09),
  parameter int unsigned      STEPS = 1,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             mode,
  output logic [WIDTH-1:0] data_out,
  output logic [STEPS-1:0] bit_out,
  output logic             zero_seed_err,
  output logic             period_pulse,
  output logic [31:0]      period_len
);

  localparam int unsigned CNT_W = 32;

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] active_seed;
  logic             mode_r;
  logic [CNT_W-1:0] cycle_cnt;

  logic [WIDTH-1:0] next_state;
  logic [STEPS-1:0] shifted_bits;
  logic [CNT_W-1:0] cnt_inc;
  logic [WIDTH-1:0] load_val;

  // One LFSR shift in the selected form; the bit leaving is always the MSB.
  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] s, input logic galois);
    logic fb;
    fb = s[WIDTH-1];
    for (int k = 1; k < int'(WIDTH); k++) begin
      if (POLY[k]) fb = fb ^ s[k-1];
    end
    if (galois) return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? POLY : '0);
    return {s[WIDTH-2:0], fb};
  endfunction

  // Unrolled STEPS-deep shift chain, collecting each shifted-out bit.
  always_comb begin
    next_state   = state;
    shifted_bits = '0;
    for (int i = 0; i < int'(STEPS); i++) begin
      shifted_bits[i] = next_state[WIDTH-1];
      next_state      = shift1(next_state, mode_r);
    end
  end

  assign cnt_inc  = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + CNT_W'(1);
  assign load_val = (seed_in == '0) ? SEED : seed_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= SEED;
      active_seed   <= SEED;
      mode_r        <= 1'b0;
      bit_out       <= '0;
      zero_seed_err <= 1'b0;
      period_pulse  <= 1'b0;
      period_len    <= '0;
      cycle_cnt     <= '0;
    end else begin
      zero_seed_err <= 1'b0;
      period_pulse  <= 1'b0;
      if (load) begin
        state         <= load_val;
        active_seed   <= load_val;
        zero_seed_err <= (seed_in == '0);
        mode_r        <= mode;
        cycle_cnt     <= '0;
      end else if (en) begin
        // A zero state would lock the register up; recover from the active seed.
        if (state == '0) begin
          state         <= active_seed;
          zero_seed_err <= 1'b1;
        end else begin
          state   <= next_state;
          bit_out <= shifted_bits;
          if (next_state == active_seed) begin
            period_pulse <= 1'b1;
            period_len   <= cnt_inc;
            cycle_cnt    <= '0;
          end else begin
            cycle_cnt <= cnt_inc;
          end
        end
      end
    end
  end

  assign data_out = state;

endmodule

// File: tb/tb_lfsr_multi.sv
// Scoreboard bench for lfsr_multi: a STEPS=1 and a STEPS=2 instance share stimulus
// and are compared each cycle against an independent reference model.
`timescale 1ns/1ps
module tb_lfsr_multi;

  localparam int unsigned      W = 7;
  localparam logic [W-1:0]     P = 7'h09;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] seed_in = '0;

  logic [W-1:0] d1, d2;
  logic [0:0]   b1;
  logic [1:0]   b2;
  logic         z1, z2, p1, p2;
  logic [31:0]  l1, l2;

  always #5 clk = ~clk;

  lfsr_multi #(.WIDTH(W), .POLY(P), .STEPS(1), .SEED(7'h01)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in), .mode(mode),
    .data_out(d1), .bit_out(b1), .zero_seed_err(z1), .period_pulse(p1), .period_len(l1)
  );

  lfsr_multi #(.WIDTH(W), .POLY(P), .STEPS(2), .SEED(7'h01)) dut2 (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in), .mode(mode),
    .data_out(d2), .bit_out(b2), .zero_seed_err(z2), .period_pulse(p2), .period_len(l2)
  );

  typedef struct packed {
    logic [W-1:0] st;
    logic [W-1:0] seed;
    logic         md;
    logic [31:0]  cnt;
    logic [31:0]  plen;
    logic [1:0]   bo;
    logic         zerr;
    logic         pp;
  } mdl_t;

  typedef struct packed {
    mdl_t a;
    mdl_t b;
  } exp_t;

  exp_t sb[$];
  mdl_t m1, m2;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Fibonacci feedback as parity over a tap mask; Galois as a conditional XOR.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] s, input logic gal);
    logic [W-1:0] mask;
    mask = (P >> 1) | 7'h40;
    if (gal) return {s[W-2:0], 1'b0} ^ (s[W-1] ? P : 7'h00);
    return {s[W-2:0], ^(s & mask)};
  endfunction

  function automatic mdl_t mdl_next(input mdl_t m, input int steps, input logic r,
                                    input logic l, input logic e,
                                    input logic [W-1:0] si, input logic md);
    mdl_t n;
    logic [31:0] inc;
    n      = m;
    n.zerr = 1'b0;
    n.pp   = 1'b0;
    if (r) begin
      n.st = 7'h01; n.seed = 7'h01; n.md = 1'b0; n.bo = 2'b00;
      n.plen = 32'd0; n.cnt = 32'd0;
    end else if (l) begin
      if (si != 7'h00) begin
        n.st = si; n.seed = si;
      end else begin
        n.st = 7'h01; n.seed = 7'h01; n.zerr = 1'b1;
      end
      n.md  = md;
      n.cnt = 32'd0;
    end else if (e) begin
      if (m.st == 7'h00) begin
        n.st   = m.seed;
        n.zerr = 1'b1;
      end else begin
        for (int i = 0; i < steps; i++) begin
          n.bo[i] = n.st[W-1];
          n.st    = ref_shift(n.st, n.md);
        end
        inc = (m.cnt == 32'hFFFF_FFFF) ? m.cnt : m.cnt + 32'd1;
        if (n.st == n.seed) begin
          n.pp = 1'b1; n.plen = inc; n.cnt = 32'd0;
        end else begin
          n.cnt = inc;
        end
      end
    end
    return n;
  endfunction

  task automatic cyc(input logic r, input logic l, input logic e,
                     input logic [W-1:0] si, input logic md);
    exp_t x;
    @(negedge clk);
    rst = r; load = l; en = e; seed_in = si; mode = md;
    m1 = mdl_next(m1, 1, r, l, e, si, md);
    m2 = mdl_next(m2, 2, r, l, e, si, md);
    sb.push_back('{m1, m2});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("d1", 32'(d1), 32'(x.a.st));
    check("b1", 32'(b1), 32'(x.a.bo[0]));
    check("z1", 32'(z1), 32'(x.a.zerr));
    check("p1", 32'(p1), 32'(x.a.pp));
    check("l1", l1, x.a.plen);
    check("d2", 32'(d2), 32'(x.b.st));
    check("b2", 32'(b2), 32'(x.b.bo));
    check("z2", 32'(z2), 32'(x.b.zerr));
    check("p2", 32'(p2), 32'(x.b.pp));
    check("l2", l2, x.b.plen);
  endtask

  logic [W-1:0] fib_exp [6] = '{7'h02, 7'h04, 7'h09, 7'h12, 7'h24, 7'h49};
  logic [W-1:0] gal_exp [8] = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h09, 7'h12};
  logic [W-1:0] ms_exp  [2] = '{7'h04, 7'h12};
  logic         seen [128];
  int           distinct;

  initial begin
    m1 = '0;
    m2 = '0;

    cyc(1'b1, 1'b0, 1'b0, 7'h00, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 7'h00, 1'b0);
    check("rst_data", 32'(d1), 32'h01);
    check("rst_bits", 32'(b2), 32'h0);
    check("rst_plen", l1, 32'd0);
    check("rst_err", 32'(z1), 32'h0);

    // Fibonacci run across one full period.
    for (int i = 0; i < 127; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 7'h00, 1'b0);
      if (i < 6) check("fib_seq", 32'(d1), 32'(fib_exp[i]));
      if (i < 2) begin
        check("ms_seq", 32'(d2), 32'(ms_exp[i]));
        check("ms_bits", 32'(b2), 32'h0);
      end
      if (i == 125) check("fib_nopulse", 32'(p1), 32'h0);
    end
    check("fib_pulse", 32'(p1), 32'h1);
    check("fib_plen", l1, 32'd127);
    check("ms_plen", l2, 32'd127);

    // Hold with en low: state and bit_out (last out bit came from 0x40) stay.
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 7'h00, 1'b1);
      check("hold_data", 32'(d1), 32'h01);
      check("hold_bits", 32'(b1), 32'h1);
      check("hold_pulse", 32'(p1), 32'h0);
    end

    // Galois run: load seed 1, every non-zero state once per period.
    cyc(1'b0, 1'b1, 1'b0, 7'h01, 1'b1);
    check("gal_load", 32'(d1), 32'h01);
    for (int i = 0; i < 128; i++) seen[i] = 1'b0;
    distinct = 0;
    for (int i = 0; i < 127; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 7'h00, 1'b0);
      if (i < 8) check("gal_seq", 32'(d1), 32'(gal_exp[i]));
      if (!seen[d1]) distinct++;
      seen[d1] = 1'b1;
    end
    check("gal_distinct", 32'(distinct), 32'd127);
    check("gal_nozero", 32'(seen[0]), 32'h0);
    check("gal_plen", l1, 32'd127);

    // Zero seed is replaced by SEED and flagged; Galois mode still latched.
    cyc(1'b0, 1'b1, 1'b0, 7'h00, 1'b1);
    check("zs_err", 32'(z1), 32'h1);
    check("zs_data", 32'(d1), 32'h01);
    cyc(1'b0, 1'b0, 1'b1, 7'h00, 1'b1);
    check("zs_err_drop", 32'(z1), 32'h0);
    check("zs_next", 32'(d1), 32'h02);

    // load beats en; mode change without load is ignored (Fibonacci stays).
    cyc(1'b0, 1'b1, 1'b1, 7'h55, 1'b0);
    check("ld_wins", 32'(d1), 32'h55);
    cyc(1'b0, 1'b0, 1'b1, 7'h00, 1'b1);
    check("mode_ignored", 32'(d1), 32'h2A);

    // rst beats load: back to SEED, Fibonacci, counters cleared.
    cyc(1'b1, 1'b1, 1'b1, 7'h33, 1'b1);
    check("rst_ld_data", 32'(d1), 32'h01);
    check("rst_ld_plen", l1, 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 7'h00, 1'b1);
    check("rst_ld_fib", 32'(d1), 32'h09);

    // Lock-up guard: zero state reloads the active seed.
    force dut.state = 7'h00;
    #1;
    release dut.state;
    m1.st = 7'h00;
    cyc(1'b0, 1'b0, 1'b1, 7'h00, 1'b0);
    check("lock_data", 32'(d1), 32'h01);
    check("lock_err", 32'(z1), 32'h1);

    // Long mixed run: STEPS=2 tracked against the single-shift model.
    for (int i = 0; i < 1000; i++) begin
      logic         e, l, md;
      logic [W-1:0] si;
      e  = ($urandom_range(0, 3) != 0);
      l  = ($urandom_range(0, 149) == 0);
      md = 1'($urandom_range(0, 1));
      si = ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom_range(0, 127));
      cyc(1'b0, l, e, si, md);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
